// File: rtl/addsub_pkg.sv
// ============================================================
// addsub_pkg: shared state encoding and sizing helpers. Rev 1.0
// ============================================================
`default_nettype none

package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_steps(input int width, input int slice);
    return width / slice;
  endfunction

  // Index counter keeps at least one bit even when a single step suffices.
  function automatic int calc_idx_w(input int steps);
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_slice.sv
// ============================================================
// addsub_slice: combinational SLICE-bit adder that also exposes
// the carry into its top bit for signed overflow. Rev 1.0
// ============================================================
`default_nettype none

module addsub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_top
);

  generate
    if (SLICE == 1) begin : g_single_bit
      assign c_top = cin;
      assign sum   = a ^ b ^ cin;
      assign cout  = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
    end else begin : g_multi_bit
      // Low bits are summed one bit wider so the MSB-1 carry falls out directly.
      logic [SLICE-1:0] w_low;
      assign w_low = {1'b0, a[SLICE-2:0]} + {1'b0, b[SLICE-2:0]}
                   + {{(SLICE-1){1'b0}}, cin};
      assign c_top = w_low[SLICE-1];
      assign sum   = {a[SLICE-1] ^ b[SLICE-1] ^ c_top, w_low[SLICE-2:0]};
      assign cout  = (a[SLICE-1] & b[SLICE-1]) | (c_top & (a[SLICE-1] ^ b[SLICE-1]));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/multicycle_addsub_flags.sv
// ============================================================
// multicycle_addsub_flags: slice-serial add/subtract with flags.
// Optional sticky overflow via ADDSUB_STICKY_OVF_EN. Rev 1.0
// ============================================================
`default_nettype none

module multicycle_addsub_flags
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             is_signed,
`ifdef ADDSUB_STICKY_OVF_EN
  input  logic             clr_sticky,
  output logic             sticky_ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int STEPS = calc_steps(WIDTH, SLICE);
  localparam int IDX_W = calc_idx_w(STEPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d, sub_q, sub_d, signed_q, signed_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_out_q, carry_out_d, overflow_q, overflow_d;
  logic               zero_q, zero_d, negative_q, negative_d;

  logic [SLICE-1:0]       w_sum;
  logic                   w_cout, w_c_top, w_last;
  logic [WIDTH+SLICE-1:0] w_acc_cat;
  logic [WIDTH-1:0]       w_acc_next;

  addsub_slice #(.SLICE(SLICE)) u_slice (
    .a     (a_q[SLICE-1:0]),
    .b     (b_q[SLICE-1:0]),
    .cin   (carry_q),
    .sum   (w_sum),
    .cout  (w_cout),
    .c_top (w_c_top)
  );

  // Slices enter at the top and shift down, so after STEPS cycles slice 0 sits at bit 0.
  assign w_acc_cat  = {w_sum, acc_q};
  assign w_acc_next = w_acc_cat[WIDTH+SLICE-1:SLICE];
  assign w_last     = (state_q == RUN) && (idx_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    signed_d    = signed_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          a_d      = a;
          b_d      = b ^ {WIDTH{sub}};
          carry_d  = sub;
          idx_d    = '0;
          sub_d    = sub;
          signed_d = is_signed;
          busy_d   = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        carry_d = w_cout;
        acc_d   = w_acc_next;
        if (w_last) begin
          state_d     = DONE;
          done_d      = 1'b1;
          result_d    = w_acc_next;
          carry_out_d = w_cout;
          overflow_d  = signed_q ? (w_c_top ^ w_cout) : (w_cout ^ sub_q);
          zero_d      = (w_acc_next == '0);
          negative_d  = w_acc_next[WIDTH-1];
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      signed_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      signed_q    <= signed_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
    end
  end

`ifdef ADDSUB_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // A set on the same edge as a clear takes priority.
  always_comb begin
    sticky_d = sticky_q;
    if (clr_sticky) sticky_d = 1'b0;
    if (w_last && overflow_d) sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_ovf = sticky_q;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_addsub_flags.sv
// ============================================================
// tb_multicycle_addsub_flags: directed vectors with a scoreboard
// monitor on done. Rev 1.0
// ============================================================
`default_nettype none

module tb_multicycle_addsub_flags;

  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int STEPS = WIDTH / SLICE;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic c, v, z, n;
    int   id;
  } exp_t;

  typedef struct {
    int               at;
    bit               pulse;
    logic [WIDTH-1:0] a, b;
    logic             sb, sg;
  } drv_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             sub = 1'b0, is_signed = 1'b0;
  logic             busy, done, carry_out, overflow, zero, negative;
  logic [WIDTH-1:0] result;
`ifdef ADDSUB_STICKY_OVF_EN
  logic             clr_sticky = 1'b0;
  logic             sticky_ovf;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  multicycle_addsub_flags #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .is_signed (is_signed),
`ifdef ADDSUB_STICKY_OVF_EN
    .clr_sticky(clr_sticky),
    .sticky_ovf(sticky_ovf),
`endif
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [WIDTH-1:0] res, input logic c, v, z, n, input int id);
    exp_t e;
    e.res = res; e.c = c; e.v = v; e.z = z; e.n = n; e.id = id;
    return e;
  endfunction

  function automatic drv_t nodrv();
    drv_t d;
    d.at = 0; d.pulse = 1'b0; d.a = '0; d.b = '0; d.sb = 1'b0; d.sg = 1'b0;
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 result=%h, required no done", result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({result, carry_out, overflow, zero, negative} !== {e.res, e.c, e.v, e.z, e.n}) begin
          errors++;
          $display("FAIL op%0d: got res=%h c=%b v=%b z=%b n=%b, required res=%h c=%b v=%b z=%b n=%b",
                   e.id, result, carry_out, overflow, zero, negative, e.res, e.c, e.v, e.z, e.n);
        end
      end
    end
  end

  // Ends just after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] ia, ib, input logic isub, isg,
                       input exp_t e, input bit push, input bit hold);
    @(negedge clk);
    a = ia; b = ib; sub = isub; is_signed = isg; start = 1'b1;
    if (push) sb_q.push_back(e);
    @(posedge clk);
    if (!hold) begin
      #1;
      start = 1'b0;
    end
  endtask

  // Call just after the accepting edge; checks latency and busy length.
  task automatic wait_done(input string tag, input drv_t d);
    int  n;
    int  bc;
    bit  seen;
    bc = 0; seen = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bc++;
      if (n == d.at) begin
        start = 1'b1; a = d.a; b = d.b; sub = d.sb; is_signed = d.sg;
      end
      if (d.pulse && n == d.at + 1) start = 1'b0;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: got no done in 20 cycles, required done", tag);
    end else begin
      chk({tag, "_latency"}, n - 1, STEPS);
      chk({tag, "_busy_cycles"}, bc, STEPS);
      chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    drv_t d;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {9'd0, result, carry_out, overflow, zero, negative, busy, done}, 32'd0);
`ifdef ADDSUB_STICKY_OVF_EN
    chk("reset_sticky", {31'd0, sticky_ovf}, 32'd0);
`endif
    rst = 1'b0;

    // Signed add overflow
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b1, mk(16'h8000, 0, 1, 0, 1, 1), 1'b1, 1'b0);
    wait_done("op1", nodrv());
    // Signed subtract overflow
    issue(16'h8000, 16'h0001, 1'b1, 1'b1, mk(16'h7FFF, 1, 1, 0, 0, 2), 1'b1, 1'b0);
    wait_done("op2", nodrv());
    // Unsigned add carry
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1, 1, 1, 0, 3), 1'b1, 1'b0);
    wait_done("op3", nodrv());
    // Unsigned subtract borrow
    issue(16'h0003, 16'h0005, 1'b1, 1'b0, mk(16'hFFFE, 0, 1, 0, 1, 4), 1'b1, 1'b0);
    wait_done("op4", nodrv());
    // Unsigned subtract without borrow
    issue(16'h0005, 16'h0003, 1'b1, 1'b0, mk(16'h0002, 1, 0, 0, 0, 5), 1'b1, 1'b0);
    wait_done("op5", nodrv());

    // Reset in the second RUN cycle aborts the operation
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, mk('0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs", {9'd0, result, carry_out, overflow, zero, negative, busy, done}, 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_idle", {30'd0, busy, done}, 32'd0);
    issue(16'h0002, 16'h0003, 1'b0, 1'b0, mk(16'h0005, 0, 0, 0, 0, 6), 1'b1, 1'b0);
    wait_done("op6", nodrv());

    // Back-to-back with start held through DONE
    issue(16'h1234, 16'h1111, 1'b0, 1'b1, mk(16'h2345, 0, 0, 0, 0, 7), 1'b1, 1'b1);
    sb_q.push_back(mk(16'h0000, 1, 0, 1, 0, 8));
    d = nodrv();
    d.at = 1; d.a = 16'h0005; d.b = 16'h0005; d.sb = 1'b1; d.sg = 1'b1;
    wait_done("op7", d);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("op8", nodrv());

    // Start pulsed during RUN is ignored
    issue(16'h4000, 16'h4000, 1'b0, 1'b1, mk(16'h8000, 0, 1, 0, 1, 9), 1'b1, 1'b0);
    d = nodrv();
    d.at = 2; d.pulse = 1'b1; d.a = 16'h0001; d.b = 16'h0001;
    wait_done("op9", d);
    repeat (6) @(negedge clk);
    chk("no_restart_busy", {31'd0, busy}, 32'd0);

`ifdef ADDSUB_STICKY_OVF_EN
    chk("sticky_after_ovf_ops", {31'd0, sticky_ovf}, 32'd1);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk("sticky_clear", {31'd0, sticky_ovf}, 32'd0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b1, mk(16'h8000, 0, 1, 0, 1, 10), 1'b1, 1'b0);
    wait_done("op10", nodrv());
    chk("sticky_set", {31'd0, sticky_ovf}, 32'd1);
    issue(16'h0002, 16'h0003, 1'b0, 1'b0, mk(16'h0005, 0, 0, 0, 0, 11), 1'b1, 1'b0);
    wait_done("op11", nodrv());
    chk("sticky_holds_clean_op", {31'd0, sticky_ovf}, 32'd1);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk("sticky_clear2", {31'd0, sticky_ovf}, 32'd0);
    clr_sticky = 1'b1;
    issue(16'h8000, 16'h0001, 1'b1, 1'b1, mk(16'h7FFF, 1, 1, 0, 0, 12), 1'b1, 1'b0);
    wait_done("op12", nodrv());
    clr_sticky = 1'b0;
    chk("sticky_set_beats_clear", {31'd0, sticky_ovf}, 32'd1);
    @(negedge clk);
    chk("sticky_after_collision", {31'd0, sticky_ovf}, 32'd1);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    chk("sticky_clear_alone", {31'd0, sticky_ovf}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_addsub_flags.md
# multicycle_addsub_flags

Parametrised, multi-cycle add/subtract unit with full status flags for the calculator datapath. It replaces the per-bit overflow cell. Operands are processed least-significant slice first, SLICE bits per cycle, through one shared slice adder. The unit reports result, carry, signed or unsigned overflow, zero and negative, with a start/done handshake and an optional sticky overflow flag.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; STEPS = WIDTH/SLICE.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when not busy.
- a  in  WIDTH  operand A; captured on the accepted start.
- b  in  WIDTH  operand B; captured on the accepted start.
- sub  in  1  0 selects A+B, 1 selects A−B (B inverted, carry-in 1); captured on start.
- is_signed  in  1  overflow rule select (1 two's-complement, 0 unsigned); captured on start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; outputs valid from this cycle.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- carry_out  out  1  carry out of the MSB.
- overflow  out  1  overflow per the captured is_signed.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- sticky_ovf  out  1  present only with the macro; see Configuration.
- clr_sticky  in  1  present only with the macro.

## Operation
- State machine has three states: IDLE, RUN and DONE.
- IDLE or DONE with start=1 → RUN. On that transition the unit latches a and b^{WIDTH{sub}}, sets carry=sub, slice index=0, and latches is_signed.
- start in RUN is ignored.
- RUN: each cycle adds slice idx with the carry register, writes the SLICE result bits, and updates the carry.
  - The final slice also records the carry into the MSB.
  - After idx=STEPS−1 → DONE.
- DONE: done=1 for exactly one cycle. Then → IDLE, or → RUN if start=1.
- Signed overflow = carry_into_MSB XOR carry_out.
- Unsigned overflow = carry_out XOR sub: a carry on add, or a borrow (carry_out=0) on subtract.
- result, carry_out, overflow, zero and negative are registered.
  - They update only on entry to DONE.
  - They hold until the next DONE entry.
- Reset values: all outputs 0. State IDLE, idx 0, internal carry 0.
- Reset mid-operation: the operation is aborted, no done pulse is produced, and all outputs return to reset values.

## Timing
- Start accepted at edge E. RUN occupies edges E+1 through E+STEPS. done is high in the cycle following edge E+STEPS.
- Latency from the accepted start to done is STEPS cycles. Throughput is one operation per STEPS+1 cycles when start is held or re-asserted in DONE.
- busy is high for exactly STEPS cycles per operation and low in the done cycle.
- SLICE=WIDTH is legal: STEPS=1, one RUN cycle.

## Configuration
- The macro is ADDSUB_STICKY_OVF_EN.
- Defined: adds the sticky_ovf output and the clr_sticky input.
  - sticky_ovf is set on DONE entry with overflow=1.
  - clr_sticky=1 clears sticky_ovf on the next edge.
  - If a set and a clear coincide, the set wins.
  - rst clears sticky_ovf.
- Undefined: both ports and the register are absent. All other behaviour is identical.

## Structure
- Package addsub_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function computing STEPS;
  - a function computing the index counter width, clog2(STEPS), minimum 1.
- Sub-module addsub_slice: combinational SLICE-bit adder. It outputs the sum, the carry out, and the carry into its top bit. It is instantiated once and shared across cycles.
- Top module contains the FSM, the operand shift/index logic, the flag registers and the sticky register.

## Test plan
All cases use WIDTH=16, SLICE=4.
- Signed add: 0x7FFF + 0x0001 → result 0x8000, overflow=1, carry_out=0, negative=1. done exactly 4 cycles after the start edge; busy high for 4 cycles.
- Signed subtract: 0x8000 − 0x0001 → result 0x7FFF, overflow=1, carry_out=1, negative=0.
- Unsigned add and subtract:
  - 0xFFFF + 0x0001 → 0x0000, zero=1, carry_out=1, overflow=1.
  - 0x0003 − 0x0005 → 0xFFFE, carry_out=0, overflow=1.
- Reset mid-operation: assert rst in the 2nd RUN cycle → no done pulse, busy=0, all outputs 0. A following 0x0002 + 0x0003 yields 0x0005 with all flags 0.
- Back-to-back and protocol: hold start through DONE → second operation begins with no IDLE cycle. A start pulsed during RUN is ignored, and its operands are not captured.
- Sticky flag, with ADDSUB_STICKY_OVF_EN defined:
  - An overflowing op followed by a clean op leaves sticky_ovf=1.
  - clr_sticky asserted in the same cycle as an overflowing DONE entry leaves sticky_ovf=1.
  - clr_sticky alone clears it.
